// File: rtl/calc_pkg.sv
// Shared calculator definitions: datapath width, operation codes,
// sequencer state encoding and mode constants used by the ALU stage
// and the register bank.
package calc_pkg;

  localparam int W = 16;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_MUL  = 2'd2,
    OP_LOAD = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  // Mode in which arithmetic is accepted, and the register-select mode.
  localparam logic [1:0] MODE_CALC = 2'd1;
  localparam logic [1:0] MODE_REG  = 2'd2;

endpackage

// File: rtl/seq_mul_u16.sv
// Unsigned shift-add multiplier, one multiplier bit per clock.
// go_i loads the operands; the N following edges each add one partial
// product. done_o is high during the cycle whose closing edge performs
// the final iteration, so product_o is complete from the next cycle on
// and stays put until the next go_i.
module seq_mul_u16 #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           go_i,
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic           done_o,
  output logic [2*N-1:0] product_o
);

  localparam int CW = $clog2(N);

  logic [2*N-1:0] mcand_q;
  logic [N-1:0]   mplier_q;
  logic [2*N-1:0] prod_q;
  logic [2*N-1:0] prod_d;
  logic [CW-1:0]  cnt_q;
  logic           run_q;

  // Partial-product accumulation for the current multiplier bit.
  always_comb begin
    prod_d = prod_q;
    if (mplier_q[0]) begin
      prod_d = prod_q + mcand_q;
    end
  end

  // Operand load on go, then one shift/add iteration per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else if (go_i) begin
      mcand_q  <= {{N{1'b0}}, a_i};
      mplier_q <= b_i;
      prod_q   <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b1;
    end else if (run_q) begin
      prod_q   <= prod_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (cnt_q == CW'(N - 1)) begin
        run_q <= 1'b0;
      end
    end
  end

  assign done_o    = run_q && (cnt_q == CW'(N - 1));
  assign product_o = prod_q;

endmodule

// File: rtl/calc_alu_seq.sv
// Calculator arithmetic stage. Captures the displayed register and the
// switch operand on an accepted start pulse, evaluates ADD/SUB/LOAD in
// one cycle or MUL over sixteen, and hands the result to the register
// bank as a single-cycle load strobe with a coincident overflow pulse.
module calc_alu_seq
  import calc_pkg::*;
#(
  parameter int         W         = calc_pkg::W,
  parameter logic [1:0] CALC_MODE = MODE_CALC
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [1:0]   mode,
  input  logic [W-1:0] operand,
  input  logic [W-1:0] acc,
  input  logic         acc_ovf,
  output logic         load,
  output logic [W-1:0] new_value,
  output logic         overflow,
  output logic         busy
);

  // Largest representable positive result, and the magnitude of the most
  // negative one, both at product width.
  localparam logic [2*W-1:0] POS_LIMIT = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic [2*W-1:0] NEG_LIMIT = {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};

  // |v| evaluated one bit wider so the most negative value negates
  // cleanly; the result always fits in W unsigned bits.
  function automatic logic [W-1:0] magnitude(input logic [W-1:0] v);
    logic [W:0] ext;
    ext = {v[W-1], v};
    if (v[W-1]) begin
      ext = -ext;
    end
    return ext[W-1:0];
  endfunction

  state_e         state_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  op_e            opr_q;
  logic           load_q;
  logic [W-1:0]   new_value_q;
  logic           overflow_q;
  logic           busy_q;

  logic           accept;
  logic           mul_go;
  logic           mul_done;
  logic [2*W-1:0] mul_prod;

  logic [W:0]     addsub_d;
  logic           mul_neg_d;
  logic [W-1:0]   mul_low_d;
  logic [W-1:0]   prod_low_d;
  logic           mul_ovf_d;
  logic [W-1:0]   result_d;
  logic           ovf_d;

  // A start only counts when idle, in calculator mode, and with an
  // unsaturated source register.
  assign accept = start && (state_q == ST_IDLE) && (mode == CALC_MODE) && !acc_ovf;
  assign mul_go = accept && (op == OP_MUL);

  // The multiplier sees magnitudes straight from the inputs so its first
  // iteration lands on the edge right after acceptance.
  seq_mul_u16 #(
    .N(W)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .go_i      (mul_go),
    .a_i       (magnitude(acc)),
    .b_i       (magnitude(operand)),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  // Result and overflow for the captured operation, consumed in WRITE.
  always_comb begin
    if (opr_q == OP_SUB) begin
      addsub_d = {a_q[W-1], a_q} - {b_q[W-1], b_q};
    end else begin
      addsub_d = {a_q[W-1], a_q} + {b_q[W-1], b_q};
    end

    // A zero product is positive regardless of operand signs.
    mul_neg_d  = (a_q[W-1] ^ b_q[W-1]) && (mul_prod != '0);
    prod_low_d = mul_prod[W-1:0];
    mul_low_d  = mul_neg_d ? -prod_low_d : prod_low_d;
    mul_ovf_d  = mul_neg_d ? (mul_prod > NEG_LIMIT) : (mul_prod > POS_LIMIT);

    result_d = addsub_d[W-1:0];
    ovf_d    = addsub_d[W] ^ addsub_d[W-1];
    case (opr_q)
      OP_MUL: begin
        result_d = mul_low_d;
        ovf_d    = mul_ovf_d;
      end
      OP_LOAD: begin
        result_d = b_q;
        ovf_d    = 1'b0;
      end
      default: ;
    endcase
  end

  // Sequencer: capture, optional multiply wait, single-cycle write-out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      opr_q       <= OP_ADD;
      load_q      <= 1'b0;
      new_value_q <= '0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      load_q     <= 1'b0;
      overflow_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            a_q    <= acc;
            b_q    <= operand;
            opr_q  <= op_e'(op);
            busy_q <= 1'b1;
            state_q <= (op == OP_MUL) ? ST_MUL : ST_WRITE;
          end
        end
        ST_MUL: begin
          // Leaving calculator mode abandons the multiply without a write.
          if (mode != CALC_MODE) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (mul_done) begin
            state_q <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          load_q      <= 1'b1;
          new_value_q <= result_d;
          overflow_q  <= ovf_d;
          state_q     <= ST_IDLE;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign load      = load_q;
  assign new_value = new_value_q;
  assign overflow  = overflow_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_calc_alu_seq.sv
// Self-checking bench for calc_alu_seq: directed cases for the corner
// behaviours plus randomized operations against an integer model.
module tb_calc_alu_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [1:0]  mode;
  logic [15:0] operand;
  logic [15:0] acc;
  logic        acc_ovf;
  logic        load;
  logic [15:0] new_value;
  logic        overflow;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  calc_alu_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .mode      (mode),
    .operand   (operand),
    .acc       (acc),
    .acc_ovf   (acc_ovf),
    .load      (load),
    .new_value (new_value),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Exact integer semantics of each operation.
  task automatic model(input logic [1:0] o, input int a, input int b,
                       output int lat, output logic [15:0] nv, output logic ov);
    longint      r;
    logic [63:0] rv;
    lat = 1;
    case (o)
      2'd0: r = longint'(a) + longint'(b);
      2'd1: r = longint'(a) - longint'(b);
      2'd2: begin
        r   = longint'(a) * longint'(b);
        lat = 17;
      end
      default: r = longint'(b);
    endcase
    rv = r;
    nv = rv[15:0];
    ov = (o != 2'd3) && ((r > 32767) || (r < -32768));
  endtask

  // One start pulse and a fixed 20-cycle observation window.
  // stray_k: cycle at which a second start is pulsed (ignored by design).
  // abort_k: cycle at which mode goes to 2, or reset is asserted.
  task automatic run_op(input string tag, input logic [1:0] o, input int a, input int b,
                        input logic [1:0] md, input logic aovf,
                        input int stray_k, input int abort_k, input bit use_rst);
    int          lat_exp;
    logic [15:0] nv_exp;
    logic        ov_exp;
    bit          acc_exp;
    int          exp_loads;
    int          loads;
    int          load_k;
    logic [15:0] seen_nv;
    logic        seen_ov;

    model(o, a, b, lat_exp, nv_exp, ov_exp);
    acc_exp   = (md == 2'd1) && !aovf;
    exp_loads = (acc_exp && abort_k < 0) ? 1 : 0;
    loads     = 0;
    load_k    = -1;
    seen_nv   = '0;
    seen_ov   = 1'b0;

    op      = o;
    acc     = 16'(a);
    operand = 16'(b);
    mode    = md;
    acc_ovf = aovf;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'(acc_exp));

    for (int k = 1; k <= 20; k++) begin
      if (k == stray_k) begin
        start = 1'b1;
        op    = 2'd0;
      end
      if (k == abort_k) begin
        if (use_rst) rst = 1'b1;
        else         mode = 2'd2;
      end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      op    = o;
      if (k == abort_k) begin
        check({tag, "_abort_busy"}, 32'(busy), 32'd0);
        if (use_rst) begin
          check({tag, "_rst_load"}, 32'(load), 32'd0);
          check({tag, "_rst_ovf"}, 32'(overflow), 32'd0);
          check({tag, "_rst_value"}, 32'(new_value), 32'd0);
        end
        rst  = 1'b0;
        mode = md;
      end
      check({tag, "_ovf_gated"}, 32'(overflow & ~load), 32'd0);
      if (load) begin
        loads++;
        if (load_k < 0) begin
          load_k  = k;
          seen_nv = new_value;
          seen_ov = overflow;
        end
      end
      if (load_k >= 0 && k == load_k + 1) begin
        check({tag, "_hold"}, 32'(new_value), 32'(seen_nv));
      end
    end

    check({tag, "_loads"}, 32'(loads), 32'(exp_loads));
    if (exp_loads == 1 && load_k >= 0) begin
      check({tag, "_latency"}, 32'(load_k), 32'(lat_exp));
      check({tag, "_value"}, 32'(seen_nv), 32'(nv_exp));
      check({tag, "_ovf"}, 32'(seen_ov), 32'(ov_exp));
    end
    n_txn++;
    $display("txn %0d %s op=%0d a=%0d b=%0d mode=%0d acc_ovf=%0d loads=%0d at=%0d value=0x%04h ovf=%0d",
             n_txn, tag, o, a, b, md, aovf, loads, load_k, seen_nv, seen_ov);
  endtask

  initial begin
    logic [1:0] ro;
    int         ra;
    int         rb;
    logic [1:0] rmd;
    logic       raovf;

    rst     = 1'b1;
    start   = 1'b0;
    op      = 2'd0;
    mode    = 2'd1;
    operand = '0;
    acc     = '0;
    acc_ovf = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_load", 32'(load), 32'd0);
    check("reset_ovf", 32'(overflow), 32'd0);
    check("reset_value", 32'(new_value), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("add",       2'd0,    100,   -30, 2'd1, 1'b0, -1, -1, 1'b0);
    run_op("sub_ovf",   2'd1, -32768,     1, 2'd1, 1'b0, -1, -1, 1'b0);
    run_op("sat_gate",  2'd0,  32767,     1, 2'd1, 1'b1, -1, -1, 1'b0);
    run_op("mul_sign",  2'd2,   -123,    45, 2'd1, 1'b0,  5, -1, 1'b0);
    run_op("mul_p256",  2'd2,    256,   128, 2'd1, 1'b0, -1, -1, 1'b0);
    run_op("mul_n256",  2'd2,   -256,   128, 2'd1, 1'b0, -1, -1, 1'b0);
    run_op("mul_min",   2'd2, -32768,    -1, 2'd1, 1'b0, -1, -1, 1'b0);
    run_op("mul_zero",  2'd2,     -5,     0, 2'd1, 1'b0, -1, -1, 1'b0);
    run_op("abort_mode",2'd2,    300,     7, 2'd1, 1'b0, -1,  8, 1'b0);
    run_op("abort_rst", 2'd2,    300,     7, 2'd1, 1'b0, -1,  8, 1'b1);
    run_op("mode_reg",  2'd0,      1,     2, 2'd2, 1'b0, -1, -1, 1'b0);
    run_op("load_op",   2'd3,    999,  1234, 2'd1, 1'b0, -1, -1, 1'b0);

    for (int i = 0; i < 150; i++) begin
      ro = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) ra = int'($urandom_range(0, 65535)) - 32768;
      else                           ra = int'($urandom_range(0, 400)) - 200;
      if ($urandom_range(0, 3) == 0) rb = int'($urandom_range(0, 65535)) - 32768;
      else                           rb = int'($urandom_range(0, 400)) - 200;
      rmd   = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'd1;
      raovf = ($urandom_range(0, 9) == 0);
      run_op("rand", ro, ra, rb, rmd, raovf, -1, -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_alu_seq.md
Name: calc_alu_seq

Overview:
Arithmetic stage directly upstream of the calculator register bank. Captures the currently displayed register value and the switch operand on a debounced start pulse, then executes ADD/SUB/MUL/LOAD. ADD/SUB/LOAD complete in a single cycle; MUL is an iterative shift-add over 16 cycles. Drives the register bank's load, new_value and overflow inputs with a one-cycle write pulse.

Parameters:
W, 16, operand/result width in bits (two's complement)
CALC_MODE, 2'd1, mode value in which operations are accepted

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  single-cycle pulse from the centre-button debouncer
op  in  2  operation select: 0 ADD, 1 SUB, 2 MUL, 3 LOAD
mode  in  2  calculator mode
operand  in  W  signed operand from the switches
acc  in  W  signed value of the selected register (register bank current_value)
acc_ovf  in  1  overflow flag of the selected register (register bank overflow_r)
load  out  1  one-cycle write strobe to the register bank
new_value  out  W  signed result, valid while load=1
overflow  out  1  one-cycle pulse, only coincident with load
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state=IDLE; load=0, overflow=0, new_value=0, busy=0. Reset mid-operation aborts with no load.
- All outputs are registered.
- start is accepted only when state=IDLE, mode==CALC_MODE and acc_ovf==0. Otherwise it is ignored with no side effects.
  - Start during busy is ignored.
  - A saturated (overflowed) register must be cleared by the bank's reset before further operations.
- Capture on the accepting edge N: a<=acc, b<=operand, opr<=op.
- States: IDLE, MUL, WRITE.
  - IDLE -> WRITE (ADD/SUB/LOAD).
  - IDLE -> MUL (MUL).
  - MUL -> WRITE after 16 iterations.
  - WRITE -> IDLE.
- ADD/SUB/LOAD: result computed at edge N. load, new_value and overflow are high for exactly the cycle after edge N+1, i.e. a latency of 1.
- MUL: unsigned magnitudes |a| and |b| are computed W+1 bits wide, so that -32768 is handled. One multiplier bit is processed per cycle on edges N+1..N+16. Load is asserted after edge N+17, a latency of 17.
- Arithmetic rules:
  - ADD/SUB use a W+1-bit signed intermediate. overflow=1 if the result is outside [-32768, 32767].
  - MUL uses a 32-bit product with the sign applied as sign(a) XOR sign(b), and a zero product is treated as positive. overflow=1 if the product is outside [-32768, 32767].
  - LOAD: new_value=b, overflow=0.
  - On overflow, new_value is the low W bits of the exact result; the load still occurs and the bank latches its sticky flag.
- Abort: if mode != CALC_MODE during the MUL state, return to IDLE next edge with no load and overflow=0.
- The result is written to whichever register is selected at load time. Register selection is mode-gated in the bank, so it cannot change while mode==CALC_MODE.
- Outside WRITE, new_value holds its last value, and load and overflow are 0.

Decomposition:
- Shared package calc_pkg contains:
  - W
  - op codes OP_ADD, OP_SUB, OP_MUL, OP_LOAD
  - the state encoding for IDLE, MUL, WRITE
  - mode constants MODE_CALC and MODE_REG (=2), shared with the register bank
- One sub-module, seq_mul_u16: unsigned 16x16 shift-add multiplier with go/done, 16-cycle latency and a 32-bit product. Sign handling and overflow detection stay in calc_alu_seq.

Test Plan:
- ADD: acc=100, operand=-30, start, mode=1 -> load high exactly 1 cycle after start; new_value=70, overflow=0, busy high for 1 cycle.
- SUB overflow: acc=-32768, operand=1 -> new_value=32767 (wrapped), overflow=1 coincident with load; the following start with acc_ovf=1 is ignored, with no load.
- MUL timing/sign: acc=-123, operand=45 -> load exactly 17 cycles after start, new_value=-5535, overflow=0; a start pulse at cycle 5 is ignored.
- MUL boundaries:
  - acc=256, operand=128 -> new_value=-32768 (0x8000), overflow=1.
  - acc=-256, operand=128 -> -32768, overflow=0.
  - acc=-32768, operand=-1 -> overflow=1.
- Abort and reset:
  - MUL 300*7; mode changed to 2 at cycle 8 -> no load, busy drops next cycle.
  - Repeat with rst at cycle 8 -> all outputs 0 next cycle.
- Gating: start with mode=2 or op=LOAD with operand=1234 in mode=1 -> the first produces no load; the second yields new_value=1234, overflow=0 after 1 cycle.
